// File: rtl/paula_audio_i2s_tx.sv
// Paula audio I2S transmitter.
// Serialises the 15-bit signed left/right mixer sums onto an I2S link (BCLK, LRCLK, SDATA).
// Each sample is widened to 16 bits by appending a zero LSB, so the sign is kept.
// The link runs freely from an internal divider of the bus clock. Inputs are sampled
// once per 32-slot frame, on the cycle frame_strobe reports.
//
// Build option:
//   PAULA_I2S_LEFT_JUSTIFIED_EN - defined: left-justified framing, so the MSB is driven in the
//                                 slot where LRCLK changes.
//                                 undefined: standard I2S, so data trails LRCLK by one BCLK.
module paula_audio_i2s_tx #(
  // Bus-clock cycles per BCLK half-period; must be >= 1.
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] ldata,
  input  logic [14:0] rdata,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_data,
  output logic        frame_strobe
);

  // Width of the divider counter. It is kept at least one bit wide so that BCLK_DIV=1 works.
  localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);
  localparam logic [4:0] LastSlot = 5'd31;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            bclk_q, bclk_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic            lrclk_q, lrclk_d;
  logic [31:0]     shift_q, shift_d;
  logic            data_q, data_d;
  logic            strobe_q, strobe_d;

  logic        div_tick;
  logic        bclk_fall;
  logic        frame_start;
  logic [31:0] capture_word;
  logic [4:0]  bit_cnt_inc;

  // Decode the divider terminal count, BCLK edges and the frame-start cycle.
  always_comb begin
    div_tick     = (div_cnt_q == DivLast);
    bclk_fall    = div_tick & bclk_q;
    frame_start  = bclk_fall & (bit_cnt_q == LastSlot);
    capture_word = {ldata, 1'b0, rdata, 1'b0};
    bit_cnt_inc  = bit_cnt_q + 5'd1;
  end

  // Next-state logic for the divider, the slot counter and the shift path.
  always_comb begin
    div_cnt_d = div_tick ? '0 : div_cnt_q + DivW'(1);
    bclk_d    = div_tick ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    shift_d   = shift_q;
    data_d    = data_q;
    strobe_d  = frame_start;

    if (bclk_fall) begin
      bit_cnt_d = bit_cnt_inc;
      // LRCLK follows the slot that starts on this edge: slots 0-15 are left, 16-31 are right.
      lrclk_d   = bit_cnt_inc[4];
      if (frame_start) begin
`ifdef PAULA_I2S_LEFT_JUSTIFIED_EN
        // The MSB goes out on the capture edge itself, together with the LRCLK change.
        data_d  = capture_word[31];
        shift_d = {capture_word[30:0], 1'b0};
`else
        // Slot 0 still carries the previous frame's right LSB. The new word starts in slot 1.
        data_d  = shift_q[31];
        shift_d = capture_word;
`endif
      end else begin
        data_d  = shift_q[31];
        shift_d = {shift_q[30:0], 1'b0};
      end
    end
  end

  // State registers with a synchronous reset. The slot counter starts at 31, so the first
  // falling edge is a frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= LastSlot;
      lrclk_q   <= 1'b1;
      shift_q   <= '0;
      data_q    <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
    end
  end

  // Drive the outputs straight from registers so that the pins are glitch-free.
  always_comb begin
    i2s_bclk     = bclk_q;
    i2s_lrclk    = lrclk_q;
    i2s_data     = data_q;
    frame_strobe = strobe_q;
  end

  // Capture always coincides with BCLK low and the start of the left slot.
  strobe_at_left_start : assert property (@(posedge clk) disable iff (reset)
    frame_strobe |-> (!i2s_bclk && !i2s_lrclk));

endmodule

// File: tb/tb_paula_audio_i2s_tx.sv
// Bench for paula_audio_i2s_tx with BCLK_DIV=2. The stimulus pushes the expected 32-bit frame
// words into a queue. A monitor deserialises SDATA on BCLK rising edges and checks each
// frame it completes against that queue.
// The bench follows PAULA_I2S_LEFT_JUSTIFIED_EN the same way the design does.
module tb_paula_audio_i2s_tx;

  localparam int unsigned Div = 2;
`ifdef PAULA_I2S_LEFT_JUSTIFIED_EN
  localparam bit Lj = 1'b1;
`else
  localparam bit Lj = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] ldata;
  logic [14:0] rdata;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_data;
  logic        frame_strobe;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  // Monitor state.
  logic        mon_prev_bclk = 1'b0;
  int          mon_r = 0;
  logic [31:0] mon_cur = '0;
  logic [31:0] mon_prv = '0;
  bit          mon_cur_act = 1'b0;
  bit          mon_prv_act = 1'b0;

  paula_audio_i2s_tx #(
    .BCLK_DIV (Div)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ldata        (ldata),
    .rdata        (rdata),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_data     (i2s_data),
    .frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [14:0] l, input logic [14:0] r);
    return {l, 1'b0, r, 1'b0};
  endfunction

  function automatic logic [14:0] fval(input int k);
    return 15'(32'h100 + k * 32'h111);
  endfunction

  task automatic sb_pop(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL frame_word: got %h want <none queued>", got);
    end else begin
      chk("frame_word", got, exp_q.pop_front());
    end
  endtask

  task automatic hold_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_bclk", 32'(i2s_bclk), 32'd0);
      chk("rst_hold_lrclk", 32'(i2s_lrclk), 32'd1);
      chk("rst_hold_data", 32'(i2s_data), 32'd0);
      chk("rst_hold_strobe", 32'(frame_strobe), 32'd0);
    end
  endtask

  // Release reset and check the first five cycles. BCLK rises at clk 2 and falls at clk 4,
  // and the frame starts at clk 4.
  task automatic restart(input logic msb);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk("start_bclk", 32'(i2s_bclk), 32'((k == 2) || (k == 3)));
      chk("start_strobe", 32'(frame_strobe), 32'(k == 4));
      chk("start_lrclk", 32'(i2s_lrclk), 32'(k < 4));
      chk("start_data", 32'(i2s_data), 32'((k >= 4) && Lj && msb));
    end
  endtask

  task automatic wait_strobe();
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1;
      if (frame_strobe) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL strobe_timeout: got no strobe want strobe within 400 clks");
    end
  endtask

  // Monitor: deserialise on BCLK rising edges. mon_r is the slot index counted from capture.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        mon_cur_act   = 1'b0;
        mon_prv_act   = 1'b0;
        mon_prev_bclk = 1'b0;
      end else begin
        if (frame_strobe) begin
          mon_prv     = mon_cur;
          mon_prv_act = mon_cur_act && !Lj;
          mon_cur     = '0;
          mon_cur_act = 1'b1;
          mon_r       = 0;
        end
        if (i2s_bclk && !mon_prev_bclk && mon_cur_act && mon_r < 32) begin
          chk("lrclk_slot", 32'(i2s_lrclk), 32'(mon_r >= 16));
          if (Lj) begin
            mon_cur[31-mon_r] = i2s_data;
            if (mon_r == 31) begin
              sb_pop(mon_cur);
              mon_cur_act = 1'b0;
            end
          end else if (mon_r == 0) begin
            if (mon_prv_act) begin
              mon_prv[0] = i2s_data;
              sb_pop(mon_prv);
              mon_prv_act = 1'b0;
            end
          end else begin
            mon_cur[32-mon_r] = i2s_data;
          end
          mon_r++;
        end
        mon_prev_bclk = i2s_bclk;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    ldata = 15'h4001;
    rdata = 15'h7FFF;
    exp_q.push_back(32'h8002_FFFE);
    hold_check(10);
    restart(1'b1);

    // Frame 2: the most negative left sample and a zero right sample.
    ldata = 15'h4000;
    rdata = 15'h0000;
    exp_q.push_back(32'h8000_0000);
    wait_strobe();

    // Frame 3: ldata changes every 7 clks. Capture lands 128 clks after the last strobe.
    rdata = 15'h1234;
    ldata = fval(0);
    exp_q.push_back(word(fval(18), 15'h1234));
    for (int c = 1; c <= 140; c++) begin
      @(posedge clk); #1;
      chk("strobe_period", 32'(frame_strobe), 32'(c == 128));
      if (c % 7 == 0) ldata = fval(c / 7);
    end
    exp_q.push_back(word(fval(20), 15'h1234));
    wait_strobe();

    // Frame 5 is abandoned by a reset at slot 20.
    ldata = 15'h2AAA;
    rdata = 15'h5555;
    exp_q.push_back(word(15'h2AAA, 15'h5555));
    repeat (82) @(posedge clk);
    #1;
    chk("mid_lrclk_slot20", 32'(i2s_lrclk), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_bclk", 32'(i2s_bclk), 32'd0);
    chk("mid_rst_lrclk", 32'(i2s_lrclk), 32'd1);
    chk("mid_rst_data", 32'(i2s_data), 32'd0);
    chk("mid_rst_strobe", 32'(frame_strobe), 32'd0);
    exp_q.delete();
    hold_check(3);

    ldata = 15'h4001;
    rdata = 15'h7FFF;
    exp_q.push_back(32'h8002_FFFE);
    restart(1'b1);
    exp_q.push_back(32'h8002_FFFE);
    wait_strobe();
    repeat (8) @(posedge clk);
    #1;
    chk("sb_left", 32'(exp_q.size()), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
